alu_mul_sequencer: RTL and testbench

- Multi-cycle 16x16 multiply controller (low 16 bits of the product) for the Hack datapath.
- Owns no adder. It sequences the external combinational ALU through shift-and-add steps by driving the ALU's x/y operands and its zx,nx,zy,ny,f,no control bits.
- Captures ALU results into internal registers.
- Presents a valid/ready handshake on both request and result sides.

---
 rtl/alu_mul_sequencer.sv | 177 +++++++++++++++++
 tb/tb_alu_mul_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_sequencer
// Brief    : 16x16 shift-and-add multiplier (low half) that steers the external
//            Hack ALU; optional early termination under MUL_EARLY_EXIT_EN.
// Revision : 1.0  initial release
// ============================================================================
module alu_mul_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zr,
    output logic             out_ng,
    output logic             busy,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic             alu_zx,
    output logic             alu_nx,
    output logic             alu_zy,
    output logic             alu_ny,
    output logic             alu_f,
    output logic             alu_no,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zr,
    input  logic             alu_ng
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADD  = 3'd1,
        S_DBL  = 3'd2,
        S_FLAG = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zr_q, zr_d;
    logic             ng_q, ng_d;
    logic [WIDTH-1:0] mplier_shr;

    assign mplier_shr = mplier_q >> 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            zr_q     <= 1'b0;
            ng_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            zr_q     <= zr_d;
            ng_q     <= ng_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        zr_d     = zr_q;
        ng_d     = ng_q;
        alu_x    = '0;
        alu_y    = '0;
        alu_zx   = 1'b0;
        alu_nx   = 1'b0;
        alu_zy   = 1'b0;
        alu_ny   = 1'b0;
        alu_f    = 1'b0;
        alu_no   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mcand_d  = in_a;
                    mplier_d = in_b;
                    acc_d    = '0;
                    cnt_d    = '0;
`ifdef MUL_EARLY_EXIT_EN
                    if (in_b == '0)
                        state_d = S_FLAG;
                    else if (in_b[0])
                        state_d = S_ADD;
                    else
                        state_d = S_DBL;
`else
                    state_d = in_b[0] ? S_ADD : S_DBL;
`endif
                end
            end

            S_ADD: begin
                alu_x   = acc_q;
                alu_y   = mcand_q;
                alu_f   = 1'b1;
                acc_d   = alu_out;
                state_d = S_DBL;
            end

            // Doubling uses mcand+mcand; the multiplier bit looked at next is
            // mplier[1], i.e. the LSB after this cycle's shift.
            S_DBL: begin
                alu_x    = mcand_q;
                alu_y    = mcand_q;
                alu_f    = 1'b1;
                mcand_d  = alu_out;
                mplier_d = mplier_shr;
                cnt_d    = cnt_q + 4'd1;
`ifdef MUL_EARLY_EXIT_EN
                if (mplier_shr == '0)
                    state_d = S_FLAG;
                else if (cnt_q == 4'd15)
                    state_d = S_FLAG;
                else
                    state_d = mplier_q[1] ? S_ADD : S_DBL;
`else
                if (cnt_q == 4'd15)
                    state_d = S_FLAG;
                else
                    state_d = mplier_q[1] ? S_ADD : S_DBL;
`endif
            end

            // x & ~0 passes acc through so the ALU produces the result flags.
            S_FLAG: begin
                alu_x   = acc_q;
                alu_y   = '0;
                alu_zy  = 1'b1;
                alu_ny  = 1'b1;
                res_d   = alu_out;
                zr_d    = alu_zr;
                ng_d    = alu_ng;
                state_d = S_DONE;
            end

            S_DONE: begin
                if (out_ready)
                    state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign out_result = res_q;
    assign out_zr     = zr_q;
    assign out_ng     = ng_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mul_sequencer
// Brief    : Self-checking bench with Hack ALU model and transaction-level
//            reference for alu_mul_sequencer.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_mul_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        out_zr;
    logic        out_ng;
    logic        busy;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
    logic [15:0] alu_out;
    logic        alu_zr;
    logic        alu_ng;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

`ifdef MUL_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
    localparam int L_3X5 = 7, L_B0 = 2, L_B7 = 8, L_B100 = 12, L_BFFFF = 34, L_B2 = 5;
`else
    localparam bit EARLY = 1'b0;
    localparam int L_3X5 = 20, L_B0 = 18, L_B7 = 21, L_B100 = 19, L_BFFFF = 34, L_B2 = 19;
`endif

    alu_mul_sequencer #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zr     (out_zr),
        .out_ng     (out_ng),
        .busy       (busy),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_zx     (alu_zx),
        .alu_nx     (alu_nx),
        .alu_zy     (alu_zy),
        .alu_ny     (alu_ny),
        .alu_f      (alu_f),
        .alu_no     (alu_no),
        .alu_out    (alu_out),
        .alu_zr     (alu_zr),
        .alu_ng     (alu_ng)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hack ALU
    logic [15:0] hx, hy, ho;
    always_comb begin
        hx = alu_zx ? 16'h0 : alu_x;
        hx = alu_nx ? ~hx : hx;
        hy = alu_zy ? 16'h0 : alu_y;
        hy = alu_ny ? ~hy : hy;
        ho = alu_f ? (hx + hy) : (hx & hy);
        ho = alu_no ? ~ho : ho;
    end
    assign alu_out = ho;
    assign alu_zr  = (ho == 16'h0);
    assign alu_ng  = ho[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Number of clock edges after the accepting edge until DONE is entered.
    function automatic int edges_to_done(input logic [15:0] b);
        int p = 0;
        int h = 0;
        for (int i = 0; i < 16; i++) begin
            if (b[i]) begin
                p = p + 1;
                h = i + 1;
            end
        end
        return 1 + (EARLY ? h : 16) + p;
    endfunction

    // Transaction-level reference: 0 idle, 1 running, 2 result pending.
    int          m_phase;
    int          m_cnt;
    logic [15:0] m_res;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_cnt   <= 0;
            m_res   <= 16'h0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_phase <= 1;
                    m_cnt   <= edges_to_done(in_b) - 1;
                    m_res   <= 16'((32'(in_a) * 32'(in_b)) & 32'hFFFF);
                end
                1: begin
                    if (m_cnt == 0) m_phase <= 2;
                    m_cnt <= m_cnt - 1;
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready, (m_phase == 0));
            chk("busy", busy, (m_phase != 0));
            chk("out_valid", out_valid, (m_phase == 2));
            if (m_phase == 0)
                chk("alu_idle", {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_x, alu_y}, 0);
            if (m_phase == 2) begin
                chk("out_result", out_result, m_res);
                chk("out_zr", out_zr, (m_res == 16'h0));
                chk("out_ng", out_ng, m_res[15]);
            end
        end
    end

    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] res, input logic zr, input logic ng,
                          input int lat, input int hold, input bit keep_valid);
        int n;
        @(negedge clk);
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_a     = ~a;
        in_b     = ~b;
        in_valid = keep_valid;
        n = 1;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, lat);
        chk("lit_result", out_result, res);
        chk("lit_zr", out_zr, zr);
        chk("lit_ng", out_ng, ng);
        repeat (hold) @(negedge clk);
        if (hold > 0) begin
            chk("hold_result", out_result, res);
            chk("hold_in_ready", in_ready, 1'b0);
            chk("hold_valid", out_valid, 1'b1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("ready_after_done", in_ready, 1'b1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = 16'h0;
        in_b      = 16'h0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_result", out_result, 16'h0);
        chk("rst_flags", {out_zr, out_ng}, 2'b00);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        run_op(16'd3,    16'd5,    16'd15,   1'b0, 1'b0, L_3X5,    0, 1'b0);
        run_op(16'h1234, 16'h0000, 16'h0000, 1'b1, 1'b0, L_B0,     0, 1'b0);
        run_op(16'hFFFD, 16'd7,    16'hFFEB, 1'b0, 1'b1, L_B7,     5, 1'b1);
        run_op(16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0, L_B100,   0, 1'b0);
        run_op(16'h0001, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, L_BFFFF,  2, 1'b1);

        // Asynchronous reset in cycle T+8 of 9*9
        begin
            int n;
            @(negedge clk);
            in_a     = 16'd9;
            in_b     = 16'd9;
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            n = 1;
            while (n < 8) begin
                @(negedge clk);
                n++;
            end
            #2 rst_n = 1'b0;
            #1;
            chk("arst_busy", busy, 1'b0);
            chk("arst_out_valid", out_valid, 1'b0);
            chk("arst_in_ready", in_ready, 1'b1);
            @(negedge clk);
            #2 rst_n = 1'b1;
        end
        run_op(16'd2, 16'd2, 16'd4, 1'b0, 1'b0, L_B2, 0, 1'b0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
